// File: rtl/fp_square.sv
// Iterative IEEE-754 single-precision squarer: out = in1 * in1.
// Radix-2 shift-add mantissa multiply, then normalise and round stages.
module fp_square #(
  parameter int unsigned W    = 32,
  parameter int unsigned M    = 22,
  parameter int unsigned E    = 30,
  parameter int unsigned BIAS = 127
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         act,
  input  logic [W-1:0] in1,
  input  logic [2:0]   round_m,
  output logic [W-1:0] out,
  output logic         ov,
  output logic         un,
  output logic         inv,
  output logic         inexact,
  output logic         busy,
  output logic         done
);

  localparam int unsigned FW  = M + 1;     // stored fraction width
  localparam int unsigned EW  = E - M;     // exponent width
  localparam int unsigned SW  = FW + 1;    // significand width with hidden bit
  localparam int unsigned PW  = 2 * SW;    // product width
  localparam int unsigned MW  = FW + 1;    // mantissa plus carry-out
  localparam int unsigned CW  = 5;         // multiply step counter width
  localparam int unsigned ERW = 10;        // signed working exponent width

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RZ  = 3'd1;
  localparam logic [2:0] RD  = 3'd2;
  localparam logic [2:0] RU  = 3'd3;
  localparam logic [2:0] RNA = 3'd4;

  localparam logic [W-1:0] FP_INFP = {1'b0, {EW{1'b1}}, {FW{1'b0}}};
  localparam logic [W-1:0] FP_NANQ = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
  localparam logic [W-1:0] FP_MAXP = {1'b0, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};

  localparam logic signed [ERW-1:0] BIAS_S = ERW'(BIAS);
  localparam logic signed [ERW-1:0] ER_MAX = ERW'((1 << EW) - 1);
  localparam logic [CW-1:0]         CNT_LAST = CW'(SW - 1);

  typedef enum logic [2:0] {
    IDLE, CLASS, MUL, NORM, ROUND, DONE
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [EW-1:0]          exp_q;
  logic [FW-1:0]          frac_q;
  logic [2:0]             rm_q;
  logic [PW-1:0]          mcand;
  logic [SW-1:0]          mplier;
  logic [PW-1:0]          prod;
  logic [FW-1:0]          mant_q;
  logic                   g_q;
  logic                   t_q;
  logic signed [ERW-1:0]  er_q;

  logic                   unused_sign;
  assign unused_sign = in1[W-1];

  // Normalise and round arithmetic feeding the NORM and ROUND states
  logic signed [ERW-1:0]  er_norm;
  logic                   inc;
  logic [MW-1:0]          mant_sum;
  logic [FW-1:0]          mant_r;
  logic signed [ERW-1:0]  er_r;
  logic                   ovf;
  logic                   unf;

  always_comb begin
    er_norm  = '0;
    inc      = 1'b0;
    mant_sum = '0;
    mant_r   = '0;
    er_r     = '0;
    ovf      = 1'b0;
    unf      = 1'b0;

    er_norm = $signed(ERW'({exp_q, 1'b0})) - BIAS_S + $signed(ERW'(prod[PW-1]));

    case (rm_q)
      RNE:     inc = g_q & (t_q | mant_q[0]);
      RNA:     inc = g_q;
      RU:      inc = g_q | t_q;
      default: inc = 1'b0;
    endcase

    mant_sum = {1'b0, mant_q} + MW'(inc);
    mant_r   = mant_sum[MW-1] ? '0 : mant_sum[FW-1:0];
    er_r     = er_q + $signed(ERW'(mant_sum[MW-1]));
    ovf      = (er_r >= ER_MAX);
    unf      = er_r[ERW-1] || (er_r == '0);
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      exp_q   <= '0;
      frac_q  <= '0;
      rm_q    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      mant_q  <= '0;
      g_q     <= 1'b0;
      t_q     <= 1'b0;
      er_q    <= '0;
      out     <= '0;
      ov      <= 1'b0;
      un      <= 1'b0;
      inv     <= 1'b0;
      inexact <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (act) begin
            exp_q  <= in1[E:M+1];
            frac_q <= in1[M:0];
            rm_q   <= round_m;
            busy   <= 1'b1;
            state  <= CLASS;
          end
        end

        CLASS: begin
          if (exp_q == '1 || exp_q == '0) begin
            ov      <= 1'b0;
            un      <= 1'b0;
            inv     <= 1'b0;
            inexact <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
            if (exp_q == '1) begin
              if (frac_q != '0) begin
                out <= FP_NANQ;
                inv <= ~frac_q[FW-1];
              end else begin
                out <= FP_INFP;
              end
            end else begin
              // Subnormal inputs square to far below the normal range
              out <= '0;
              if (frac_q != '0) begin
                un      <= 1'b1;
                inexact <= 1'b1;
              end
            end
          end else begin
            mcand  <= PW'({1'b1, frac_q});
            mplier <= {1'b1, frac_q};
            prod   <= '0;
            cnt    <= '0;
            state  <= MUL;
          end
        end

        MUL: begin
          if (mplier[0]) begin
            prod <= prod + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state <= NORM;
          end
        end

        NORM: begin
          if (prod[PW-1]) begin
            mant_q <= prod[PW-2 -: FW];
            g_q    <= prod[PW-FW-2];
            t_q    <= |prod[PW-FW-3:0];
          end else begin
            mant_q <= prod[PW-3 -: FW];
            g_q    <= prod[PW-FW-3];
            t_q    <= |prod[PW-FW-4:0];
          end
          er_q  <= er_norm;
          state <= ROUND;
        end

        ROUND: begin
          ov      <= 1'b0;
          un      <= 1'b0;
          inv     <= 1'b0;
          inexact <= g_q | t_q;
          if (ovf) begin
            ov      <= 1'b1;
            inexact <= 1'b1;
            out     <= (rm_q == RZ || rm_q == RD) ? FP_MAXP : FP_INFP;
          end else if (unf) begin
            un      <= 1'b1;
            inexact <= 1'b1;
            out     <= '0;
          end else begin
            out <= {1'b0, er_r[EW-1:0], mant_r};
          end
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_square.sv
// Directed-vector bench for fp_square: result/flag table plus latency,
// re-pulse and mid-operation reset sequences.
module tb_fp_square;

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RZ  = 3'd1;
  localparam logic [2:0] RD  = 3'd2;
  localparam logic [2:0] RU  = 3'd3;
  localparam logic [2:0] RNA = 3'd4;

  logic        clk;
  logic        rst;
  logic        act;
  logic [31:0] in1;
  logic [2:0]  round_m;
  logic [31:0] out;
  logic        ov;
  logic        un;
  logic        inv;
  logic        inexact;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  fp_square dut (
    .clk     (clk),
    .rst     (rst),
    .act     (act),
    .in1     (in1),
    .round_m (round_m),
    .out     (out),
    .ov      (ov),
    .un      (un),
    .inv     (inv),
    .inexact (inexact),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags field is {ov, un, inv, inexact}
  typedef struct {
    logic [31:0] in1;
    logic [2:0]  rm;
    logic [31:0] out;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp_v);
    end
  endtask

  // Start an operation; returns in cycle 0 (#1 after the act-sampling edge)
  task automatic start_op(input logic [31:0] a, input logic [2:0] rm);
    @(negedge clk);
    in1     = a;
    round_m = rm;
    act     = 1'b1;
    @(posedge clk);
    #1;
    act = 1'b0;
  endtask

  // Step cycles until done rises or the budget runs out
  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (done !== 1'b1 && cyc < start + 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic watch_no_done(input string name, input int ncyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    check(name, 64'(seen), 64'(0));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    string tag;
    tag = $sformatf("vec%0d", idx);
    start_op(v.in1, v.rm);
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      check({tag, "_busy"}, 64'(busy), 64'(1));
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(v.lat));
    check({tag, "_result"}, 64'({out, ov, un, inv, inexact}), 64'({v.out, v.flags}));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'({done, busy}), 64'(0));
  endtask

  initial begin
    int cyc;

    vecs[0]  = '{32'h40400000, RNE, 32'h41100000, 4'b0000, 27};
    vecs[1]  = '{32'h3F800001, RNE, 32'h3F800002, 4'b0001, 27};
    vecs[2]  = '{32'h3F800001, RU,  32'h3F800003, 4'b0001, 27};
    vecs[3]  = '{32'h3F800001, RZ,  32'h3F800002, 4'b0001, 27};
    vecs[4]  = '{32'h7F000000, RNE, 32'h7F800000, 4'b1001, 27};
    vecs[5]  = '{32'h7F000000, RZ,  32'h7F7FFFFF, 4'b1001, 27};
    vecs[6]  = '{32'h1F800000, RNE, 32'h00000000, 4'b0101, 27};
    vecs[7]  = '{32'hC0400000, RNE, 32'h41100000, 4'b0000, 27};
    vecs[8]  = '{32'hFF800000, RNE, 32'h7F800000, 4'b0000, 1};
    vecs[9]  = '{32'h7FA00000, RNE, 32'h7FC00000, 4'b0010, 1};
    vecs[10] = '{32'h7FC00000, RNE, 32'h7FC00000, 4'b0000, 1};
    vecs[11] = '{32'h80000000, RNE, 32'h00000000, 4'b0000, 1};
    vecs[12] = '{32'h00000001, RNE, 32'h00000000, 4'b0101, 1};
    vecs[13] = '{32'h3FC00001, RNE, 32'h40100002, 4'b0001, 27};
    vecs[14] = '{32'h3FC00001, RNA, 32'h40100002, 4'b0001, 27};
    vecs[15] = '{32'h3FC00001, RD,  32'h40100001, 4'b0001, 27};
    vecs[16] = '{32'h7F000000, RU,  32'h7F800000, 4'b1001, 27};
    vecs[17] = '{32'h7F000000, RD,  32'h7F7FFFFF, 4'b1001, 27};

    rst     = 1'b1;
    act     = 1'b0;
    in1     = '0;
    round_m = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'({out, ov, un, inv, inexact, busy, done}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // act raised again mid-operation must be ignored
    start_op(32'h40400000, RNE);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    in1 = 32'h3F800001;
    act = 1'b1;
    @(posedge clk);
    #1;
    act = 1'b0;
    wait_done(6, cyc);
    check("repulse_latency", 64'(cyc), 64'(27));
    check("repulse_result", 64'({out, ov, un, inv, inexact}), 64'({32'h41100000, 4'b0000}));
    watch_no_done("repulse_single_done", 40);

    // reset at e10 aborts the operation
    start_op(32'h40400000, RNE);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midop_reset", 64'({out, ov, un, inv, inexact, busy, done}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    watch_no_done("midop_reset_no_done", 40);

    run_vec(100, vecs[13]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_square.md
Name: fp_square

Overview:
- Iterative IEEE-754 single-precision squarer computing out = in1 × in1; the inverse operation of the FPU's square-root unit.
- Sits beside the sqrt unit in the FPU. It shares the rounding-mode encodings (RNe, RZ, RD, RU, RNa) and the special-value constants (FP_INFP, FP_NANQ) from the common special-characters definitions, and uses the same flag set.
- Mantissa product comes from a radix-2 shift-add multiplier (one partial product per cycle), followed by normalise and round stages.

Parameters:
- W, 32, total word width
- M, 22, MSB index of the stored mantissa field
- E, 30, MSB index of the exponent field
- BIAS, 127, exponent bias

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- act  input  1  start pulse; sampled only in IDLE
- in1  input  W  operand; captured on the act-sampling edge
- round_m  input  3  rounding mode; captured with in1
- out  output  W  result; held until the next result loads
- ov  output  1  overflow flag
- un  output  1  underflow flag
- inv  output  1  invalid flag (sNaN input)
- inexact  output  1  inexact flag
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when out and flags become valid

Behaviour:
- Reset: while rst=1 at an edge, state←IDLE; out, ov, un, inv, inexact, busy, done all ←0; counter and datapath ←0. Reset mid-operation aborts the operation; no done is produced.
- Timing convention: act=1 is sampled at edge e0; "cycle k" is the period following edge ek.
- FSM states:
  - IDLE: on act=1, capture in1 and round_m, go to CLASS. act in any other state is ignored (no queueing).
  - CLASS: unpack and classify the operand. A special case loads out/flags at e1 and goes to DONE. Otherwise go to MUL with cnt=0 and the 24-bit significand {1, frac}.
  - MUL: 24 cycles, one add-shift per edge into a 48-bit product P; cnt runs 0..23. At cnt=23 go to NORM.
  - NORM: select the mantissa window and compute the exponent.
  - ROUND: apply rounding; load out/flags at e27; go to DONE.
  - DONE: done=1 for this single cycle; return to IDLE.
- Latency: special cases → done in cycle 1; normal → done in cycle 27. The next act is accepted in the cycle after DONE.
- Sign of out is always 0, including for negative inputs.
- Special cases (resolved in CLASS):
  - NaN (exp=255, frac≠0) → out=FP_NANQ (0x7FC00000); inv=1 iff frac[22]=0 (sNaN).
  - ±inf → out=0x7F800000.
  - ±0 → out=0x00000000.
  - Subnormal nonzero → out=+0, un=1, inexact=1.
  - ov is 0 for every special case.
- Normalise:
  - e = biased input exponent; Er = 2e − BIAS, held in 10-bit signed arithmetic.
  - If P[47]=1: mant=P[46:24], g=P[23], t=|P[22:0], Er+=1.
  - Else: mant=P[45:23], g=P[22], t=|P[21:0].
- Round, with g = round bit and t = sticky:
  - RNe: increment if g&(t|mant[0]).
  - RNa: increment if g.
  - RU: increment if g|t.
  - RZ, RD, and any unused code: truncate.
  - A mantissa carry-out sets mant=0 and Er+=1.
- Inexact: inexact = g|t.
- Overflow, checked after rounding: if Er ≥ 255, set ov=1 and inexact=1.
  - RNe, RNa, RU → out=0x7F800000.
  - RZ, RD → out=0x7F7FFFFF.
- Underflow: if Er ≤ 0, out=+0, un=1, inexact=1. No subnormal outputs are produced.
- Flags are not sticky: every result load overwrites all four flags.

Test Plan:
- 3.0 (0x40400000), RNe, act at e0 → busy cycles 0–26; done cycle 27 only; out=0x41100000 (9.0); all flags 0.
- 0x3F800001, RNe → 0x3F800002, inexact=1. Same operand with RU → 0x3F800003. With RZ → 0x3F800002.
- 0x7F000000 (2^127): RNe → 0x7F800000, ov=1, inexact=1; RZ → 0x7F7FFFFF, ov=1.
- 0x1F800000 (2^-64) → 0x00000000, un=1, inexact=1. −3.0 (0xC0400000) → 0x41100000, all flags 0.
- Specials, each done in cycle 1:
  - 0xFF800000 → 0x7F800000.
  - 0x7FA00000 → 0x7FC00000, inv=1.
  - 0x7FC00000 → 0x7FC00000, inv=0.
  - 0x80000000 → 0x00000000.
- Control and reset:
  - act re-pulsed in cycle 5 is ignored; only one done, in cycle 27.
  - rst=1 at e10 → all outputs 0, state IDLE, no done.
  - A new act after reset completes normally.
